// File: rtl/srl_chain_checker.sv
// Stimulus generator and checker for an SRL delay chain.
// Sequence: flush the chain, measure latency with a marker, then stream PRBS7 and compare.
module srl_chain_checker #(
    parameter int unsigned EXPECTED_DELAY = 32,
    parameter int unsigned MAX_DELAY      = 128,
    parameter int unsigned ERR_CNT_WIDTH  = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CE,
    output logic                     SRL_D,
    input  logic                     SRL_Q,
    output logic [7:0]               MEASURED,
    output logic                     LOCKED,
    output logic                     ERROR,
    output logic [ERR_CNT_WIDTH-1:0] ERR_CNT
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned HIST_W = MAX_DELAY + 1;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_PROBE,
        S_WAIT,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [6:0]        lfsr;
    logic [HIST_W-1:0] hist;

    logic       marker_hit;
    logic       go_run;
    logic       srl_d_next;
    logic [6:0] lfsr_next;

    // Next stimulus bit is shared by SRL_D and history bit 0 so both always agree.
    always_comb begin
        marker_hit = 1'b0;
        go_run     = 1'b0;
        srl_d_next = 1'b0;
        lfsr_next  = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        case (state)
            S_FLUSH: srl_d_next = (cnt == CNT_W'(MAX_DELAY - 1));
            S_PROBE, S_WAIT: begin
                marker_hit = SRL_Q;
                go_run     = SRL_Q && (cnt == CNT_W'(EXPECTED_DELAY));
                srl_d_next = go_run ? lfsr[6] : 1'b0;
            end
            S_RUN:   srl_d_next = lfsr[6];
            default: srl_d_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_FLUSH;
            cnt      <= '0;
            SRL_D    <= 1'b0;
            MEASURED <= '0;
            LOCKED   <= 1'b0;
            ERROR    <= 1'b0;
            ERR_CNT  <= '0;
            lfsr     <= 7'h7F;
            hist     <= '0;
        end else if (CE) begin
            SRL_D <= srl_d_next;
            hist  <= {hist[HIST_W-2:0], srl_d_next};
            case (state)
                S_FLUSH: begin
                    if (cnt == CNT_W'(MAX_DELAY - 1)) begin
                        state <= S_PROBE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PROBE, S_WAIT: begin
                    if (marker_hit) begin
                        MEASURED <= cnt;
                        if (go_run) begin
                            state  <= S_RUN;
                            LOCKED <= 1'b1;
                            lfsr   <= lfsr_next;
                        end else begin
                            state <= S_FAIL;
                            ERROR <= 1'b1;
                        end
                    end else if (cnt == CNT_W'(MAX_DELAY)) begin
                        MEASURED <= 8'hFF;
                        state    <= S_FAIL;
                        ERROR    <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= S_WAIT;
                    end
                end
                S_RUN: begin
                    lfsr <= lfsr_next;
                    // History index EXPECTED_DELAY is what the chain should be emitting now.
                    if (SRL_Q != hist[EXPECTED_DELAY]) begin
                        ERROR <= 1'b1;
                        if (ERR_CNT != '1) begin
                            ERR_CNT <= ERR_CNT + ERR_CNT_WIDTH'(1);
                        end
                    end
                end
                S_FAIL: begin
                    LOCKED <= 1'b0;
                    ERROR  <= 1'b1;
                end
                default: begin
                    state  <= S_FAIL;
                    LOCKED <= 1'b0;
                    ERROR  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srl_chain_checker.sv
// Directed bench for srl_chain_checker: a modelled SRL chain of selectable length
// plus a second instance in zero-delay wire loopback.
module tb_srl_chain_checker;

    localparam int unsigned MAXD = 128;
    localparam int unsigned EXPD = 32;
    localparam int unsigned ECW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, ce;
    logic           srl_d, srl_q;
    logic [7:0]     measured;
    logic           locked, error;
    logic [ECW-1:0] err_cnt;

    logic           srl_d0;
    logic [7:0]     measured0;
    logic           locked0, error0;
    logic [15:0]    err_cnt0;

    logic [7:0]     chain_len;
    logic           tie0, inv;
    logic [255:0]   pipe = '0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [ECW-1:0] err_q[$];
    logic           prbs_q[$];
    logic [6:0]     lfsr_m;

    srl_chain_checker #(.EXPECTED_DELAY(EXPD), .MAX_DELAY(MAXD), .ERR_CNT_WIDTH(ECW)) dut (
        .CLK(clk), .RST(rst), .CE(ce), .SRL_D(srl_d), .SRL_Q(srl_q),
        .MEASURED(measured), .LOCKED(locked), .ERROR(error), .ERR_CNT(err_cnt)
    );

    srl_chain_checker #(.EXPECTED_DELAY(0), .MAX_DELAY(8), .ERR_CNT_WIDTH(16)) dut0 (
        .CLK(clk), .RST(rst), .CE(ce), .SRL_D(srl_d0), .SRL_Q(srl_d0),
        .MEASURED(measured0), .LOCKED(locked0), .ERROR(error0), .ERR_CNT(err_cnt0)
    );

    // Chain model: SRL_Q(t) = SRL_D(t - chain_len) in CE cycles.
    always @(posedge clk) if (ce) pipe <= {pipe[254:0], srl_d};
    always_comb srl_q = tie0 ? 1'b0 : (pipe[chain_len - 8'd1] ^ inv);

    task automatic step(input logic ce_v);
        ce = ce_v;
        @(posedge clk);
        #1;
        if (ce_v && !rst) cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step(1'b1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_srl_d"},    32'(srl_d),    0);
        check({tag, "_measured"}, 32'(measured), 0);
        check({tag, "_locked"},   32'(locked),   0);
        check({tag, "_error"},    32'(error),    0);
        check({tag, "_err_cnt"},  32'(err_cnt),  0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ce = 1'b1; tie0 = 1'b0; inv = 1'b0; chain_len = 8'd32;

        // Correct 32-stage chain, CE always on
        do_reset();
        check_reset_values("rst");
        check("wire_rst_locked", 32'(locked0), 0);
        while (cyc < 127) begin
            step(1'b1);
            if (cyc == 8) check("wire_unlocked_c8", 32'(locked0), 0);
            if (cyc == 9) begin
                check("wire_locked_c9", 32'(locked0), 1);
                check("wire_measured", 32'(measured0), 0);
            end
        end
        check("flush_d_c127", 32'(srl_d), 0);
        step(1'b1);
        check("probe_d_c128", 32'(srl_d), 1);
        step(1'b1);
        check("wait_d_c129", 32'(srl_d), 0);
        run_to(160);
        check("unlocked_c160", 32'(locked), 0);
        step(1'b1);
        check("locked_c161", 32'(locked), 1);
        check("measured_32", 32'(measured), 32);

        // PRBS7 stream on SRL_D from the first RUN cycle
        lfsr_m = 7'h7F;
        for (int i = 0; i < 300; i++) begin
            prbs_q.push_back(lfsr_m[6]);
            lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
            check("prbs_d", 32'(srl_d), 32'(prbs_q.pop_front()));
            step(1'b1);
        end
        check("run_err_cnt", 32'(err_cnt), 0);
        check("run_error", 32'(error), 0);

        // Invert SRL_Q for 3 cycles, then 6 more to hit saturation
        for (int i = 0; i < 3; i++) begin
            inv = 1'b1;
            err_q.push_back(ECW'(i + 1));
            step(1'b1);
            check("inj_err_cnt", 32'(err_cnt), 32'(err_q.pop_front()));
        end
        inv = 1'b0;
        check("inj_error", 32'(error), 1);
        check("inj_locked", 32'(locked), 1);
        for (int i = 0; i < 5; i++) step(1'b1);
        check("inj_err_cnt_hold", 32'(err_cnt), 3);
        for (int i = 0; i < 6; i++) begin
            inv = 1'b1;
            err_q.push_back((i + 4 > 7) ? ECW'(7) : ECW'(i + 4));
            step(1'b1);
            check("sat_err_cnt", 32'(err_cnt), 32'(err_q.pop_front()));
        end
        inv = 1'b0;
        step(1'b1);
        check("sat_locked", 32'(locked), 1);

        // Reset pulse with CE low still resets, then relock
        rst = 1'b1;
        step(1'b0);
        check_reset_values("rst_pulse");
        rst = 1'b0;
        cyc = 0;
        run_to(161);
        check("relock_locked", 32'(locked), 1);
        check("relock_measured", 32'(measured), 32);
        check("relock_err_cnt", 32'(err_cnt), 0);

        // Chain one stage short
        chain_len = 8'd31;
        do_reset();
        run_to(159);
        check("short_error_c159", 32'(error), 0);
        step(1'b1);
        check("short_measured", 32'(measured), 31);
        check("short_error", 32'(error), 1);
        check("short_locked", 32'(locked), 0);
        for (int i = 0; i < 50; i++) begin
            step(1'b1);
            check("fail_srl_d", 32'(srl_d), 0);
        end
        check("fail_locked", 32'(locked), 0);
        check("fail_err_cnt", 32'(err_cnt), 0);

        // Chain one stage long
        chain_len = 8'd33;
        do_reset();
        run_to(161);
        check("long_locked_c161", 32'(locked), 0);
        check("long_error_c161", 32'(error), 0);
        step(1'b1);
        check("long_measured", 32'(measured), 33);
        check("long_error", 32'(error), 1);

        // Random CE: SRL_D/LOCKED follow CE-qualified cycles and hold otherwise
        chain_len = 8'd32;
        do_reset();
        for (int g = 0; g < 3000 && cyc < 260; g++) begin
            step(1'($urandom_range(0, 1)));
            check("rce_locked", 32'(locked), 32'(cyc >= 161));
            if (cyc <= 160) check("rce_srl_d", 32'(srl_d), 32'(cyc == 128));
        end
        check("rce_cycle_budget", 32'(cyc), 260);
        check("rce_measured", 32'(measured), 32);
        check("rce_err_cnt", 32'(err_cnt), 0);
        check("rce_error", 32'(error), 0);

        // SRL_Q stuck at 0: timeout
        tie0 = 1'b1;
        do_reset();
        run_to(256);
        check("to_error_c256", 32'(error), 0);
        check("to_measured_c256", 32'(measured), 0);
        step(1'b1);
        check("to_measured", 32'(measured), 32'hFF);
        check("to_error", 32'(error), 1);
        check("to_locked", 32'(locked), 0);

        check("wire_err_cnt", 32'(err_cnt0), 0);
        check("wire_error", 32'(error0), 0);
        check("wire_locked_end", 32'(locked0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
